program_encoder: RTL and testbench

- Inverse of the core's instruction decoder: accepts abstract instruction descriptors (operation, registers, immediate) and encodes them into 32-bit RV32I machine words.
- Writes the encoded words sequentially into instruction memory through a write port.
- Used by the boot/test loader to build programs on-chip.
- Covers the ops the core decodes: ADD, SUB, SLL, ADDI, LW, SW, BEQ.

---
 rtl/program_encoder.sv | 164 ++++++++++++++++
 tb/tb_program_encoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder.sv
// program_encoder: turns instruction descriptors (op, registers, immediate)
// into RV32I machine words and streams them into instruction memory, one
// word per cycle, starting at a base word address captured on start.
module program_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active-low
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [12:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err,
    output logic [2:0]            err_code
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_RANGE  = 3'd1;
    localparam logic [2:0] E_ALIGN  = 3'd2;
    localparam logic [2:0] E_OPCODE = 3'd3;
    localparam logic [2:0] E_FULL   = 3'd4;

    localparam logic [6:0] OPC_R = 7'b0110011;

    // Memory capacity in words, expressed in the count width.
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_reg, state_next;
    logic                    start_ok;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   ptr_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [ADDR_WIDTH:0]     count_pending;
    logic                    we_reg;
    logic [31:0]             wdata_reg;
    logic                    err_reg;
    logic [2:0]              err_code_reg;
    logic [31:0]             word_next;
    logic [2:0]              chk_next;
    logic signed [12:0]      imm_s;
    logic                    is_is_type;
    logic                    range_bad;
    logic                    align_bad;

    assign imm_s  = in_imm;
    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic and handshake; start only counts when idle.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        start_ok   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = S_FLUSH;
            end
            S_FLUSH: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Encode the presented descriptor and classify it; the word in flight
    // is included in the fill level so back-to-back accepts see FULL in time.
    always_comb begin
        word_next = 32'h0;
        case (in_op)
            OP_ADD:  word_next = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SUB:  word_next = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SLL:  word_next = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OPC_R};
            OP_ADDI: word_next = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            OP_LW:   word_next = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            OP_SW:   word_next = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            OP_BEQ:  word_next = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                                  in_imm[4:1], in_imm[11], 7'b1100011};
            default: word_next = 32'h0;
        endcase

        is_is_type    = (in_op == OP_ADDI) || (in_op == OP_LW) || (in_op == OP_SW);
        range_bad     = (is_is_type && ((imm_s < -13'sd2048) || (imm_s > 13'sd2047))) ||
                        ((in_op == OP_BEQ) && (imm_s > 13'sd4094));
        align_bad     = (in_op == OP_BEQ) && in_imm[0];
        count_pending = count_reg + {{ADDR_WIDTH{1'b0}}, we_reg};

        chk_next = E_NONE;
        if (in_op == 3'd7)                 chk_next = E_OPCODE;
        else if (range_bad)                chk_next = E_RANGE;
        else if (align_bad)                chk_next = E_ALIGN;
        else if (count_pending == CAPACITY) chk_next = E_FULL;
    end

    // Write pipeline, pointer/count and sticky first-error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg       <= 1'b0;
            wdata_reg    <= 32'h0;
            ptr_reg      <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= E_NONE;
        end else begin
            we_reg <= accept && (chk_next == E_NONE);
            if (accept && (chk_next == E_NONE)) wdata_reg <= word_next;

            if (start_ok) begin
                ptr_reg      <= base_addr;
                count_reg    <= '0;
                err_reg      <= 1'b0;
                err_code_reg <= E_NONE;
            end else begin
                if (we_reg) begin
                    ptr_reg   <= ptr_reg + 1'b1;
                    count_reg <= count_reg + 1'b1;
                end
                if (accept && (chk_next != E_NONE)) begin
                    err_reg <= 1'b1;
                    if (!err_reg) err_code_reg <= chk_next;
                end
            end
        end
    end

    assign mem_we    = we_reg;
    assign mem_addr  = ptr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != S_IDLE);
    assign count     = count_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: directed loads plus randomized loads, checked
// against an instruction-level reference model with an expected-write queue.
module tb_program_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_s;
    logic [7:0]  base_addr;
    logic [1:0]  base_s;
    logic        in_valid, in_last;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;

    logic        in_ready, mem_we, busy, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic [2:0]  err_code;

    logic        in_ready_s, mem_we_s, busy_s, err_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  count_s;
    logic [2:0]  err_code_s;

    program_encoder #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .count(count), .err(err),
        .err_code(err_code)
    );

    program_encoder #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .base_addr(base_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .busy(busy_s), .count(count_s), .err(err_s),
        .err_code(err_code_s)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          addr;
        logic [31:0] word;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    int   m_base, m_written, m_aw, m_code, tgt;
    bit   m_err;
    bit   acc_flag;
    int   cyc = 0;

    // RV32I instruction word assembled field by field with arithmetic.
    function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2, int imm);
        longint w;
        longint b31;
        b31 = longint'(1) << 31;
        w = 0;
        case (op)
            0: w = rs2 * 1048576 + rs1 * 32768 + rd * 128 + 51;
            1: w = 32 * 33554432 + rs2 * 1048576 + rs1 * 32768 + rd * 128 + 51;
            2: w = rs2 * 1048576 + rs1 * 32768 + 1 * 4096 + rd * 128 + 51;
            3: w = (imm & 4095) * 1048576 + rs1 * 32768 + rd * 128 + 19;
            4: w = (imm & 4095) * 1048576 + rs1 * 32768 + 2 * 4096 + rd * 128 + 3;
            5: w = ((imm >>> 5) & 127) * 33554432 + rs2 * 1048576 + rs1 * 32768
                   + 2 * 4096 + (imm & 31) * 128 + 35;
            6: w = ((imm >>> 12) & 1) * b31 + ((imm >>> 5) & 63) * 33554432
                   + rs2 * 1048576 + rs1 * 32768 + ((imm >>> 1) & 15) * 256
                   + ((imm >>> 11) & 1) * 128 + 99;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic int ref_code(int op, int imm, int written, int aw);
        if (op == 7) return 3;
        if ((op >= 3 && op <= 5) && (imm < -2048 || imm > 2047)) return 1;
        if (op == 6 && (imm < -4096 || imm > 4094)) return 1;
        if (op == 6 && (imm % 2 != 0)) return 2;
        if (written == (1 << aw)) return 4;
        return 0;
    endfunction

    task automatic model_accept();
        int  imm;
        int  c;
        wr_t w;
        imm = int'($signed(in_imm));
        c = ref_code(int'(in_op), imm, m_written, m_aw);
        if (c == 0) begin
            w.addr = (m_base + m_written) % (1 << m_aw);
            w.word = ref_word(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), imm);
            w.cyc  = cyc + 1;
            exp_q.push_back(w);
            m_written++;
        end else if (!m_err) begin
            m_err  = 1'b1;
            m_code = c;
        end
        acc_flag = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor first, then handshake observer (both away from the edge).
    always @(negedge clk) begin
        wr_t w;
        if (mem_we || mem_we_s) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_we", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check_val("waddr", mem_we ? 32'(mem_addr) : 32'(mem_addr_s), 32'(w.addr));
                check_val("wdata", mem_we ? mem_wdata : mem_wdata_s, w.word);
                check_val("wcycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (rst) begin
            if (in_valid && in_ready)   model_accept();
            if (in_valid && in_ready_s) model_accept();
        end
    end

    // ---------------- drivers ----------------
    task automatic do_start(input int base, input int t);
        in_valid  = 1'b0;
        tgt       = t;
        m_base    = base;
        m_written = 0;
        m_err     = 1'b0;
        m_code    = 0;
        m_aw      = (t != 0) ? 2 : 8;
        if (t != 0) begin start_s = 1'b1; base_s = base[1:0]; end
        else        begin start   = 1'b1; base_addr = base[7:0]; end
        @(posedge clk); #1;
        start   = 1'b0;
        start_s = 1'b0;
        check_val("start_busy",  32'(tgt != 0 ? busy_s : busy), 32'd1);
        check_val("start_ready", 32'(tgt != 0 ? in_ready_s : in_ready), 32'd1);
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input bit last, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_op    = op[2:0];
        in_rd    = rd[4:0];
        in_rs1   = rs1[4:0];
        in_rs2   = rs2[4:0];
        in_imm   = imm[12:0];
        in_last  = last;
        in_valid = 1'b1;
        acc_flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_flag) break;
        end
        if (!acc_flag) check_val("accept_timeout", 32'd0, 32'd1);
        acc_flag = 1'b0;
        #1;
    endtask

    // Called right after the last accept: in_valid stays high through FLUSH.
    task automatic finish_load(input bit start_in_flush);
        check_val("flush_busy",  32'(tgt != 0 ? busy_s : busy), 32'd1);
        check_val("flush_ready", 32'(tgt != 0 ? in_ready_s : in_ready), 32'd0);
        if (start_in_flush) begin
            if (tgt != 0) start_s = 1'b1; else start = 1'b1;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        start_s  = 1'b0;
        in_valid = 1'b0;
        check_val("idle_busy", 32'(tgt != 0 ? busy_s : busy), 32'd0);
        check_val("count",     32'(tgt != 0 ? 9'(count_s) : count), 32'(m_written));
        check_val("err",       32'(tgt != 0 ? err_s : err), 32'(m_err));
        check_val("err_code",  32'(tgt != 0 ? err_code_s : err_code), 32'(m_code));
        check_val("drain",     32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, imm, op, sel;
        rst = 1'b0; start = 1'b0; start_s = 1'b0; base_addr = '0; base_s = '0;
        in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_imm = '0;
        tgt = 0; m_aw = 8; m_base = 0; m_written = 0; m_err = 1'b0; m_code = 0;
        #2;
        check_val("rst_we",    32'(mem_we), 32'd0);
        check_val("rst_addr",  32'(mem_addr), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_err",   32'({err, err_code}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // R-type trio, back to back; start pulse while busy is ignored.
        do_start(32'h10, 0);
        start = 1'b1; base_addr = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        send(0, 3, 1, 2, 0, 1'b0, 0);
        send(1, 3, 1, 2, 0, 1'b0, 0);
        send(2, 3, 1, 2, 0, 1'b1, 0);
        finish_load(1'b0);
        $display("load R-type: count=%0d err_code=%0d", count, err_code);

        // I/S/B-type encodings.
        do_start(32'h40, 0);
        send(3, 5, 0, 0, -1, 1'b0, 0);
        send(4, 4, 1, 0, 16, 1'b0, 0);
        send(5, 0, 1, 2, 8, 1'b0, 0);
        send(6, 0, 1, 2, -4, 1'b1, 0);
        finish_load(1'b0);
        $display("load I/S/B: count=%0d err_code=%0d", count, err_code);

        // Illegal descriptors; start during FLUSH must be ignored.
        do_start(32'h30, 0);
        send(3, 1, 2, 0, 2048, 1'b0, 0);
        send(6, 0, 1, 2, 3, 1'b0, 0);
        send(7, 1, 1, 1, 0, 1'b0, 0);
        send(0, 3, 1, 2, 0, 1'b1, 0);
        finish_load(1'b1);
        $display("load illegal: count=%0d err_code=%0d", count, err_code);

        // Address wrap and FULL on a 4-word memory.
        do_start(3, 1);
        for (int i = 0; i < 5; i++) send(0, i + 1, 2, 3, 0, (i == 4), 0);
        finish_load(1'b0);
        $display("load wrap: count=%0d err_code=%0d", count_s, err_code_s);

        // Reset one cycle after an accept: pending word is lost.
        do_start(32'h20, 0);
        send(0, 3, 1, 2, 0, 1'b0, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_val("mid_rst_we",    32'(mem_we), 32'd0);
        check_val("mid_rst_addr",  32'(mem_addr), 32'd0);
        check_val("mid_rst_wdata", mem_wdata, 32'd0);
        check_val("mid_rst_busy",  32'(busy), 32'd0);
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_err",   32'({err, err_code}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_start(32'h50, 0);
        send(4, 7, 8, 0, -2048, 1'b0, 0);
        send(6, 0, 9, 10, 4094, 1'b1, 1);
        finish_load(1'b0);
        $display("load after reset: count=%0d err_code=%0d", count, err_code);

        // Randomized loads on both instances.
        for (int l = 0; l < 12; l++) begin
            sel = l % 2;
            do_start($urandom_range(0, 255), sel);
            n = (sel != 0) ? $urandom_range(1, 7) : $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                op = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
                if ($urandom_range(0, 5) == 0)  imm = $urandom_range(0, 8191) - 4096;
                else if (op == 6)               imm = 2 * $urandom_range(0, 4095) - 4096;
                else                            imm = $urandom_range(0, 4095) - 2048;
                send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     imm, (i == n - 1), $urandom_range(0, 2));
            end
            finish_load(1'b0);
            $display("load rand %0d: dut=%0d n=%0d written=%0d err_code=%0d",
                     l, sel, n, m_written, m_code);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
